// File: rtl/if_id_stage.sv
// IF/ID pipeline boundary register.
// Valid/ready handshake, flush to bubbles, optional skid entry.
//
// Purpose:
//   Holds fetched instruction + PC between fetch and decode.
//   SKID = 1 keeps a second entry so in_ready comes straight
//   from a flop; SKID = 0 is a single register with a
//   combinational in_ready.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   in_valid/in_ready      fetch-side handshake
//   instr_in, pc_in        fetched instruction and its PC
//   flush                  kill held and offered entries
//   out_valid/out_ready    decode-side handshake
//   instr_out              instruction, NOP_INSTR when idle
//   pc_out                 PC, holds last value when idle

module if_id_stage #(
    parameter int unsigned        INSTR_W   = 16,
    parameter int unsigned        PC_W      = 16,
    parameter bit                 SKID      = 1'b1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    logic   main_valid;
    entry_t main_q;
    entry_t in_e;
    logic   out_xfer;

    assign in_e.instr = instr_in;
    assign in_e.pc    = pc_in;
    assign out_xfer   = main_valid && out_ready;

    assign out_valid = main_valid;
    assign instr_out = main_valid ? main_q.instr : NOP_INSTR;
    assign pc_out    = main_q.pc;

    generate
        if (SKID) begin : g_skid
            logic   skid_valid;
            entry_t skid_q;
            logic   in_xfer;

            // skid_valid is a flop, so in_ready has no path
            // from out_ready; flush still forces it high.
            assign in_ready = !skid_valid || flush;
            assign in_xfer  = in_valid && !skid_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_q     <= '0;
                    skid_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else begin
                    // skid is only ever valid with main valid
                    unique case (1'b1)
                        !main_valid: begin
                            if (in_xfer) begin
                                main_valid <= 1'b1;
                                main_q     <= in_e;
                            end
                        end
                        main_valid && !skid_valid: begin
                            if (in_xfer && out_xfer) begin
                                main_q <= in_e;
                            end else if (in_xfer) begin
                                skid_valid <= 1'b1;
                                skid_q     <= in_e;
                            end else if (out_xfer) begin
                                main_valid <= 1'b0;
                            end
                        end
                        skid_valid: begin
                            if (out_xfer) begin
                                main_q     <= skid_q;
                                skid_valid <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = out_ready || !main_valid || flush;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    main_valid <= 1'b0;
                    main_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (in_valid && in_ready) begin
                    main_valid <= 1'b1;
                    main_q     <= in_e;
                end else if (out_ready) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
